// File: rtl/shift_seq_pkg.sv
// Shared types and widths for the shift sequencer and its shifter.
package shift_seq_pkg;

    localparam int DATA_W   = 4;
    localparam int AMT_W    = 3;
    localparam int STEP_MAX = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Largest pass the shifter can take from the remaining amount.
    function automatic logic [1:0] pass_step(input logic [AMT_W-1:0] rem);
        return (rem > AMT_W'(STEP_MAX)) ? 2'(STEP_MAX) : rem[1:0];
    endfunction

endpackage

// File: rtl/shifter.sv
// Purpose: 4-bit logical shifter, one pass of 0..3 positions, left or right.
// Latency: combinational.
// Backpressure: none; shamt 0 passes data_in through unchanged.
module shifter
    import shift_seq_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic              sr,
    input  logic [1:0]        shamt,
    output logic [DATA_W-1:0] data_out
);

    always_comb begin
        data_out = data_in;
        if (shamt != 2'd0) begin
            data_out = sr ? (data_in >> shamt) : (data_in << shamt);
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Purpose: shares one shifter between two requesters, splitting amounts 0..7 into passes of <=3.
// Latency: accept to resp_valid is ceil(amt/3)+1 cycles (1 cycle for amt 0).
// Backpressure: readies are low outside IDLE; the result holds in DONE until resp_ready.
module shift_sequencer
    import shift_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_sr,
    input  logic [AMT_W-1:0]  req0_amt,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_sr,
    input  logic [AMT_W-1:0]  req1_amt,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                sr_q, sr_d;
    logic [AMT_W-1:0]    rem_q, rem_d;
    logic                id_q, id_d;
    logic                last_grant_q, last_grant_d;

    logic                gnt_id;
    logic                idle_ok;
    logic [1:0]          step;
    logic [1:0]          shamt;
    logic [DATA_W-1:0]   sh_out;
    logic [AMT_W-1:0]    gnt_amt;

    shifter u_shifter (
        .data_in  (acc_q),
        .sr       (sr_q),
        .shamt    (shamt),
        .data_out (sh_out)
    );

    // Round-robin pointer: on a tie the requester not granted last wins.
    always_comb begin
        gnt_id     = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;
        idle_ok    = (state_q == IDLE) && !rst;
        req0_ready = idle_ok && req0_valid && !gnt_id;
        req1_ready = idle_ok && req1_valid && gnt_id;
        gnt_amt    = gnt_id ? req1_amt : req0_amt;
        step       = pass_step(rem_q);
        // The shifter never sees shamt 0; outside SHIFT its output is unused.
        shamt      = (state_q == SHIFT) ? step : 2'd1;
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        sr_d         = sr_q;
        rem_d        = rem_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    acc_d        = gnt_id ? req1_data : req0_data;
                    sr_d         = gnt_id ? req1_sr : req0_sr;
                    rem_d        = gnt_amt;
                    id_d         = gnt_id;
                    last_grant_d = gnt_id;
                    state_d      = (gnt_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_d = sh_out;
                rem_d = rem_q - {1'b0, step};
                if (rem_q <= AMT_W'(STEP_MAX)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            sr_q         <= 1'b0;
            rem_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            sr_q         <= sr_d;
            rem_q        <= rem_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign resp_valid = (state_q == DONE);
    assign resp_data  = acc_q;
    assign resp_id    = id_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: vector table plus hand-written multi-cycle sequences.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_data, req1_data;
    logic       req0_sr, req1_sr;
    logic [2:0] req0_amt, req1_amt;
    logic       resp_valid, resp_ready, resp_id;
    logic [3:0] resp_data;

    int total = 0;
    int bad = 0;
    int shamt0_cnt = 0;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_sr    (req0_sr),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_sr    (req1_sr),
        .req1_amt   (req1_amt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
    );

    always @(negedge clk) begin
        if (!rst && dut.u_shifter.shamt == 2'd0) shamt0_cnt++;
    end

    typedef struct {
        logic       id;
        logic [3:0] data;
        logic       sr;
        logic [2:0] amt;
        logic [3:0] exp_data;
        int         exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic id, input logic v, input logic [3:0] d,
                         input logic s, input logic [2:0] a);
        if (id) begin
            req1_valid = v; req1_data = d; req1_sr = s; req1_amt = a;
        end else begin
            req0_valid = v; req0_data = d; req0_sr = s; req0_amt = a;
        end
    endtask

    // Counts falling edges after the accept edge until resp_valid is seen.
    task automatic wait_resp(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
    endtask

    task automatic wait_ready(input logic id, output logic rdy);
        int n = 0;
        rdy = id ? req1_ready : req0_ready;
        while (!rdy && n < 20) begin
            @(negedge clk); #1;
            rdy = id ? req1_ready : req0_ready;
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   lat;
        logic rdy;
        @(negedge clk);
        drive(v.id, 1'b1, v.data, v.sr, v.amt);
        #1;
        wait_ready(v.id, rdy);
        chk("vec_accept", rdy, 1);
        @(posedge clk); #1;
        drive(v.id, 1'b0, v.data, v.sr, v.amt);
        wait_resp(lat);
        chk("vec_latency", lat, v.exp_lat);
        chk("vec_data", resp_data, v.exp_data);
        chk("vec_id", resp_id, v.id);
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic rdy;
        logic exp_id;

        //        id    data     sr    amt   exp      lat
        vecs[0] = '{1'b0, 4'b0011, 1'b0, 3'd1, 4'b0110, 2};
        vecs[1] = '{1'b1, 4'b1000, 1'b1, 3'd5, 4'b0000, 3};
        vecs[2] = '{1'b0, 4'b1010, 1'b0, 3'd0, 4'b1010, 1};
        vecs[3] = '{1'b1, 4'b1011, 1'b1, 3'd2, 4'b0010, 2};
        vecs[4] = '{1'b0, 4'b0001, 1'b0, 3'd7, 4'b0000, 4};
        vecs[5] = '{1'b1, 4'b1111, 1'b0, 3'd3, 4'b1000, 2};
        vecs[6] = '{1'b0, 4'b1100, 1'b1, 3'd2, 4'b0011, 2};
        vecs[7] = '{1'b1, 4'b0110, 1'b0, 3'd4, 4'b0000, 3};
        vecs[8] = '{1'b0, 4'b1001, 1'b1, 3'd3, 4'b0001, 2};
        vecs[9] = '{1'b1, 4'b0101, 1'b1, 3'd1, 4'b0010, 2};

        rst = 1'b1;
        resp_ready = 1'b1;
        drive(1'b0, 1'b1, 4'b0001, 1'b0, 3'd1);
        drive(1'b1, 1'b1, 4'b1000, 1'b1, 3'd1);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_id", resp_id, 0);
        rst = 1'b0;
        #1;

        // Both requesters held valid from reset: grants go 0, 1, 0.
        for (int g = 0; g < 3; g++) begin
            int n = 0;
            exp_id = (g == 1);
            while (!(req0_ready || req1_ready) && n < 20) begin
                @(negedge clk); #1;
                n++;
            end
            chk("rr_grant_req1", req1_ready, exp_id);
            chk("rr_other_ready", exp_id ? req0_ready : req1_ready, 0);
            @(posedge clk);
            wait_resp(lat);
            chk("rr_latency", lat, 2);
            chk("rr_resp_id", resp_id, exp_id);
            chk("rr_resp_data", resp_data, exp_id ? 4'b0100 : 4'b0010);
            if (g == 2) begin
                drive(1'b0, 1'b0, 4'b0001, 1'b0, 3'd1);
                drive(1'b1, 1'b0, 4'b1000, 1'b1, 3'd1);
            end
            @(posedge clk);
            @(negedge clk); #1;
        end

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Response back-pressure with requester 0 waiting behind it.
        @(negedge clk);
        resp_ready = 1'b0;
        drive(1'b1, 1'b1, 4'b0110, 1'b0, 3'd2);
        #1;
        wait_ready(1'b1, rdy);
        chk("bp_accept", rdy, 1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 4'b0110, 1'b0, 3'd2);
        drive(1'b0, 1'b1, 4'b0011, 1'b0, 3'd1);
        wait_resp(lat);
        chk("bp_latency", lat, 2);
        for (int i = 0; i < 4; i++) begin
            chk("bp_resp_valid", resp_valid, 1);
            chk("bp_resp_data", resp_data, 4'b1000);
            chk("bp_resp_id", resp_id, 1);
            chk("bp_req0_ready", req0_ready, 0);
            chk("bp_req1_ready", req1_ready, 0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_ready_before_hs", req0_ready, 0);
        @(posedge clk);
        @(negedge clk); #1;
        chk("bp_ready_after_hs", req0_ready, 1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'b0011, 1'b0, 3'd1);
        wait_resp(lat);
        chk("bp_next_latency", lat, 2);
        chk("bp_next_data", resp_data, 4'b0110);
        chk("bp_next_id", resp_id, 0);
        @(posedge clk);

        // Reset during the second SHIFT cycle of an amt-7 request.
        @(negedge clk);
        drive(1'b0, 1'b1, 4'b1111, 1'b0, 3'd7);
        #1;
        wait_ready(1'b0, rdy);
        chk("mid_accept", rdy, 1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'b1111, 1'b0, 3'd7);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        chk("mid_resp_valid", resp_valid, 0);
        chk("mid_resp_data", resp_data, 0);
        chk("mid_req0_ready_in_rst", req0_ready, 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            chk("mid_no_resp", resp_valid, 0);
        end
        drive(1'b0, 1'b1, 4'b0100, 1'b1, 3'd2);
        drive(1'b1, 1'b1, 4'b0001, 1'b0, 3'd1);
        #1;
        chk("mid_tie_req0", req0_ready, 1);
        chk("mid_tie_req1", req1_ready, 0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'b0100, 1'b1, 3'd2);
        drive(1'b1, 1'b0, 4'b0001, 1'b0, 3'd1);
        wait_resp(lat);
        chk("mid_after_latency", lat, 2);
        chk("mid_after_data", resp_data, 4'b0001);
        chk("mid_after_id", resp_id, 0);
        @(posedge clk);
        @(negedge clk);

        chk("shamt_zero_seen", shamt0_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
